// File: rtl/spi_master_multi_if.sv
// Command-side bundle of the multi-mode SPI master.
// The front end (master modport) drives requests; the engine (slave modport) reports status.
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = $clog2(NUM_SS)
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [SEL_W-1:0]  ss_sel;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  clk_div;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output start, tx_data, ss_sel,
    output cpol, cpha, lsb_first, clk_div,
    input  busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, ss_sel,
    input  cpol, cpha, lsb_first, clk_div,
    output busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_multi.sv
// Full-duplex SPI frame engine: four CPOL/CPHA modes,
// selectable bit order, one-hot active-low slave selects.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = $clog2(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_multi_if.slave cmd,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int HP_W = $clog2(2*DATA_W);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(2*DATA_W-1);

  logic [1:0]        state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [HP_W-1:0]   hp;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpha_q;
  logic              lsb_q;

  function automatic logic head(
    input logic [DATA_W-1:0] v,
    input logic              lsb
  );
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop(
    input logic [DATA_W-1:0] v,
    input logic              lsb
  );
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] push(
    input logic [DATA_W-1:0] v,
    input logic              b,
    input logic              lsb
  );
    return lsb ? {b, v[DATA_W-1:1]}
               : {v[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_SS-1:0] sel_dec(
    input logic [SEL_W-1:0] s
  );
    logic [NUM_SS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (s == SEL_W'(i)) r[i] = 1'b0;
    return r;
  endfunction

  logic              half_end;
  logic              drv_bit;
  logic              cap_bit;
  logic [DATA_W-1:0] rx_fin;

  assign half_end = (cnt == div_q);
  // hp even ends with a leading edge, hp odd with a trailing edge
  assign drv_bit = cpha_q ? ~hp[0]
                          : (hp[0] && hp != HP_LAST);
  assign cap_bit = cpha_q ? (~hp[0] && hp != '0)
                          : hp[0];
  assign rx_fin = cpha_q ? push(rx_sh, miso, lsb_q)
                         : rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_q       <= '0;
      hp          <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      ss_n        <= '1;
      cmd.busy    <= 1'b0;
      cmd.done    <= 1'b0;
      cmd.rx_data <= '0;
    end else begin
      cmd.done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cmd.cpol;
          mosi <= 1'b0;
          ss_n <= '1;
          if (cmd.start) begin
            state    <= SETUP;
            cmd.busy <= 1'b1;
            cnt      <= '0;
            div_q    <= cmd.clk_div;
            cpha_q   <= cmd.cpha;
            lsb_q    <= cmd.lsb_first;
            ss_n     <= sel_dec(cmd.ss_sel);
            rx_sh    <= '0;
            if (cmd.cpha) begin
              tx_sh <= cmd.tx_data;
            end else begin
              mosi  <= head(cmd.tx_data, cmd.lsb_first);
              tx_sh <= drop(cmd.tx_data, cmd.lsb_first);
            end
          end
        end
        SETUP: begin
          if (half_end) begin
            cnt   <= '0;
            hp    <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (half_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
            hp   <= hp + 1'b1;
            if (hp == HP_LAST) state <= HOLD;
            if (drv_bit) begin
              mosi  <= head(tx_sh, lsb_q);
              tx_sh <= drop(tx_sh, lsb_q);
            end
            if (cap_bit)
              rx_sh <= push(rx_sh, miso, lsb_q);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (half_end) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd.busy    <= 1'b0;
            cmd.done    <= 1'b1;
            cmd.rx_data <= rx_fin;
            ss_n        <= '1;
            mosi        <= 1'b0;
            sclk        <= cmd.cpol;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: behavioural SPI slave plus
// frame-level timing and data expectations.
module tb_spi_master_multi;
  localparam int DATA_W = 8;
  localparam int NUM_SS = 5;
  localparam int DIV_W  = 8;
  localparam int SEL_W  = $clog2(NUM_SS);

  logic              clk = 1'b0;
  logic              rst;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;

  spi_master_multi_if #(
    .DATA_W(DATA_W), .NUM_SS(NUM_SS),
    .DIV_W(DIV_W), .SEL_W(SEL_W)
  ) cmd ();

  spi_master_multi #(
    .DATA_W(DATA_W), .NUM_SS(NUM_SS),
    .DIV_W(DIV_W), .SEL_W(SEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd),
    .miso(miso),
    .sclk(sclk),
    .mosi(mosi),
    .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  // slave model state
  bit                s_en   = 1'b0;
  bit                s_loop = 1'b0;
  bit                s_cpol, s_cpha, s_lsb;
  logic [DATA_W-1:0] s_tx;
  logic [DATA_W-1:0] s_rx;
  logic              s_first;
  int                s_bi, s_ri, s_tog;
  int                tog_cyc[$];

  always @(sclk) begin
    bit lead;
    if (s_en) begin
      s_tog = s_tog + 1;
      tog_cyc.push_back(cyc);
      lead = (sclk !== s_cpol);
      if (lead ^ s_cpha) begin
        if (s_ri < DATA_W) begin
          s_rx[s_lsb ? s_ri : DATA_W-1-s_ri] = mosi;
          if (s_ri == 0) s_first = mosi;
        end
        s_ri = s_ri + 1;
      end else begin
        s_bi = s_bi + 1;
      end
    end
  end

  always_comb begin
    miso = 1'b0;
    if (s_en && s_loop)
      miso = mosi;
    else if (s_en && s_bi >= 0 && s_bi < DATA_W)
      miso = s_tx[s_lsb ? s_bi : DATA_W-1-s_bi];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [DATA_W-1:0] tx,
                         input bit pol, input bit pha,
                         input bit lsb,
                         input logic [DIV_W-1:0] div,
                         input logic [SEL_W-1:0] sel);
    cmd.tx_data   = tx;
    cmd.ss_sel    = sel;
    cmd.cpol      = pol;
    cmd.cpha      = pha;
    cmd.lsb_first = lsb;
    cmd.clk_div   = div;
  endtask

  task automatic run_frame(input string nm,
                           input logic [DATA_W-1:0] tx,
                           input logic [DATA_W-1:0] srx,
                           input bit pol, input bit pha,
                           input bit lsb,
                           input logic [DIV_W-1:0] div,
                           input logic [SEL_W-1:0] sel,
                           input bit loop);
    int h, n, busy_n, done_at, ss_bad, sp_bad, c0, lim;
    logic [NUM_SS-1:0] exp_ss;
    logic [DATA_W-1:0] exp_rx;
    h = int'(div) + 1;
    exp_ss = '1;
    if (int'(sel) < NUM_SS) exp_ss[sel] = 1'b0;
    exp_rx = loop ? tx : srx;
    @(negedge clk);
    cmd.start = 1'b0;
    set_cfg(tx, pol, pha, lsb, div, sel);
    @(negedge clk);
    chk({nm, ":idle_sclk"}, 64'(sclk), 64'(pol));
    s_tx = srx; s_cpol = pol; s_cpha = pha;
    s_lsb = lsb; s_loop = loop;
    s_bi = pha ? -1 : 0;
    s_ri = 0; s_rx = '0; s_tog = 0;
    s_first = 1'bx;
    tog_cyc.delete();
    s_en = 1'b1;
    cmd.start = 1'b1;
    @(negedge clk);
    cmd.start = 1'b0;
    c0 = cyc;
    n = 1; busy_n = 0; done_at = 0; ss_bad = 0;
    lim = 4 * (2*DATA_W+2) * h + 20;
    while (done_at == 0 && n < lim) begin
      if (cmd.busy === 1'b1) begin
        busy_n++;
        if (ss_n !== exp_ss) ss_bad++;
      end
      if (cmd.done === 1'b1) done_at = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    s_en = 1'b0;
    chk({nm, ":done_cycle"}, 64'(done_at),
        64'((2*DATA_W+2)*h + 1));
    chk({nm, ":busy_cycles"}, 64'(busy_n),
        64'((2*DATA_W+2)*h));
    chk({nm, ":ss_n"}, 64'(ss_bad), 64'(0));
    chk({nm, ":ss_n_done"}, 64'(ss_n), 64'({NUM_SS{1'b1}}));
    chk({nm, ":rx_data"}, 64'(cmd.rx_data), 64'(exp_rx));
    chk({nm, ":mosi_word"}, 64'(s_rx), 64'(tx));
    chk({nm, ":toggles"}, 64'(s_tog), 64'(2*DATA_W));
    sp_bad = 0;
    for (int i = 1; i < tog_cyc.size(); i++)
      if (tog_cyc[i] - tog_cyc[i-1] != h) sp_bad++;
    chk({nm, ":spacing"}, 64'(sp_bad), 64'(0));
    if (tog_cyc.size() > 0)
      chk({nm, ":last_toggle"},
          64'(tog_cyc[tog_cyc.size()-1] - c0),
          64'((2*DATA_W+1)*h));
    @(negedge clk);
    chk({nm, ":done_pulse"}, 64'(cmd.done), 64'(0));
    chk({nm, ":idle_sclk_after"}, 64'(sclk), 64'(pol));
  endtask

  initial begin
    int n, dones, hi, run, max_run, dbad, lim;
    cmd.start = 1'b0;
    set_cfg('0, 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:busy", 64'(cmd.busy), 64'(0));
    chk("rst:done", 64'(cmd.done), 64'(0));
    chk("rst:rx_data", 64'(cmd.rx_data), 64'(0));
    chk("rst:sclk", 64'(sclk), 64'(0));
    chk("rst:mosi", 64'(mosi), 64'(0));
    chk("rst:ss_n", 64'(ss_n), 64'({NUM_SS{1'b1}}));
    rst = 1'b0;

    run_frame("m0_loop", 8'hA5, 8'h00, 0, 0, 0, 0, 0, 1);
    run_frame("m1", 8'($urandom), 8'h3C, 0, 1, 0, 3, 1, 0);
    run_frame("m2", 8'($urandom), 8'h3C, 1, 0, 0, 3, 3, 0);
    run_frame("m3", 8'($urandom), 8'h3C, 1, 1, 0, 3, 4, 0);
    run_frame("lsb", 8'h01, 8'h80, 0, 0, 1, 1, 2, 0);
    chk("lsb:first_mosi", 64'(s_first), 64'(1));
    run_frame("oor5", 8'h5A, 8'hC3, 0, 0, 0, 0, 5, 0);
    run_frame("oor7", 8'h96, 8'h2D, 1, 1, 1, 2, 7, 0);
    run_frame("maxdiv", 8'hE1, 8'h7B, 0, 1, 1, 8'hFF, 0, 0);

    for (int k = 0; k < 10; k++)
      run_frame($sformatf("rnd%0d", k),
                8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom_range(0, 3)),
                3'($urandom_range(0, 6)), 0);

    // start held high: frames chain with a one-cycle deselect gap
    @(negedge clk);
    set_cfg(8'h3A, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
    cmd.start = 1'b1;
    @(negedge clk);
    dones = 0; hi = 0; run = 0; max_run = 0; dbad = 0;
    for (int c = 1; c <= 58; c++) begin
      if (c == 58) cmd.start = 1'b0;
      if (cmd.done === 1'b1) begin
        dones++;
        if (c != 19 * dones) dbad++;
      end
      if (ss_n[2] === 1'b1) begin
        hi++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(negedge clk);
    end
    chk("b2b:dones", 64'(dones), 64'(3));
    chk("b2b:done_pos", 64'(dbad), 64'(0));
    chk("b2b:ss_hi_cycles", 64'(hi), 64'(3));
    chk("b2b:ss_gap_len", 64'(max_run), 64'(1));
    n = 59;
    while (cmd.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b:last_done", 64'(n), 64'(76));
    lim = 0;
    repeat (40) begin
      @(negedge clk);
      if (cmd.done === 1'b1) lim++;
    end
    chk("b2b:no_extra", 64'(lim), 64'(0));

    // reset in the middle of a frame
    set_cfg(8'hC7, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
    @(negedge clk);
    cmd.start = 1'b1;
    @(negedge clk);
    cmd.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst:ss_n", 64'(ss_n), 64'({NUM_SS{1'b1}}));
    chk("mid_rst:sclk", 64'(sclk), 64'(0));
    chk("mid_rst:busy", 64'(cmd.busy), 64'(0));
    chk("mid_rst:rx_data", 64'(cmd.rx_data), 64'(0));
    dones = 0;
    repeat (30) begin
      if (cmd.done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("mid_rst:no_done", 64'(dones), 64'(0));
    run_frame("post_rst", 8'h6E, 8'h91, 0, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
